// File: rtl/ps2_keyboard_ctrl_pkg.sv
// Scan-code set 2 constants and small helpers shared by the PS/2 keyboard front end.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_M     = 8'h3A;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_EQ    = 8'h55;
  localparam logic [7:0] SC_MINUS = 8'h4E;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam logic [7:0] SC_DIGIT [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  localparam logic [3:0] SET_A = 4'b0001;
  localparam logic [3:0] SET_W = 4'b0010;
  localparam logic [3:0] SET_S = 4'b0100;
  localparam logic [3:0] SET_D = 4'b1000;

  localparam logic [15:0] SHIFT_LIMIT = 16'hFFF0;

  // {hit, value}: hit is set when code is one of the ten digit keys
  function automatic logic [4:0] digit_decode(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (code == SC_DIGIT[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [15:0] step);
    return (v >= SHIFT_LIMIT - step) ? SHIFT_LIMIT : v + step;
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] v, input logic [15:0] step);
    return (v <= step) ? '0 : v - step;
  endfunction

endpackage

// File: rtl/ps2_keyboard_ctrl_if.sv
// Raw PS/2 lines plus the decoded control outputs of the keyboard front end.
interface ps2_kbd_if;
  logic        ps2_clock;
  logic        ps2_data;
  logic        start;
  logic        pause;
  logic        clear;
  logic        manual;
  logic [3:0]  setting;
  logic [15:0] file_id;
  logic [15:0] shift_x;
  logic [15:0] shift_y;
  logic [3:0]  scroll;

  modport master (
    input  ps2_clock, ps2_data,
    output start, pause, clear, manual, setting, file_id, shift_x, shift_y, scroll
  );

  modport slave (
    output ps2_clock, ps2_data,
    input  start, pause, clear, manual, setting, file_id, shift_x, shift_y, scroll
  );
endinterface

// File: rtl/ps2_keyboard_ctrl_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling, frame check and idle timeout.
module ps2_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned TO_RAW = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int unsigned TO_CYC = (TO_RAW < 2) ? 2 : TO_RAW;
  localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

  logic [2:0]      clk_sync;
  logic [2:0]      dat_sync;
  logic [10:0]     shreg;
  logic [10:0]     frame;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            fall;
  logic            frame_ok;

  assign fall     = (clk_sync[2:1] == 2'b10);
  assign frame    = {dat_sync[1], shreg[10:1]};
  assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clock};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (fall) begin
        shreg    <= frame;
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_data  <= frame[8:1];
            rx_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        // a stalled partial frame is abandoned so the next start bit realigns
        if (idle_cnt == TO_W'(TO_CYC - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard front end: scan-code decoder driving run control, edit cursor, preset and view registers.
module ps2_keyboard_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 200,
  parameter int SHIFT_STEP = 16,
  parameter int SCROLL_MAX = 4
) (
  input logic          clk_vga,
  input logic          reset_btn,
  ps2_kbd_if.master    kbd
);

  localparam logic [15:0] STEP = 16'(SHIFT_STEP);
  localparam logic [3:0]  SMAX = 4'(SCROLL_MAX);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ext;
  logic       brk;
  logic [4:0] digit;

  ps2_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .ps2_clock (kbd.ps2_clock),
    .ps2_data  (kbd.ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  assign digit = digit_decode(rx_data);

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      kbd.start   <= 1'b0;
      kbd.pause   <= 1'b0;
      kbd.clear   <= 1'b0;
      kbd.manual  <= 1'b0;
      kbd.setting <= '0;
      kbd.file_id <= '0;
      kbd.shift_x <= '0;
      kbd.shift_y <= '0;
      kbd.scroll  <= '0;
    end else begin
      kbd.start   <= 1'b0;
      kbd.pause   <= 1'b0;
      kbd.clear   <= 1'b0;
      kbd.setting <= '0;
      if (rx_valid) begin
        if (rx_data == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_data == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk && ext) begin
            case (rx_data)
              SC_LEFT:  kbd.shift_x <= sat_sub(kbd.shift_x, STEP);
              SC_RIGHT: kbd.shift_x <= sat_add(kbd.shift_x, STEP);
              SC_UP:    kbd.shift_y <= sat_sub(kbd.shift_y, STEP);
              SC_DOWN:  kbd.shift_y <= sat_add(kbd.shift_y, STEP);
              default:  ;
            endcase
          end else if (!brk) begin
            case (rx_data)
              SC_ENTER: kbd.start  <= 1'b1;
              SC_SPACE: kbd.pause  <= 1'b1;
              SC_C:     kbd.clear  <= 1'b1;
              SC_M:     kbd.manual <= !kbd.manual;
              SC_A:     if (kbd.manual) kbd.setting <= SET_A;
              SC_W:     if (kbd.manual) kbd.setting <= SET_W;
              SC_S:     if (kbd.manual) kbd.setting <= SET_S;
              SC_D:     if (kbd.manual) kbd.setting <= SET_D;
              SC_EQ:    if (kbd.scroll < SMAX) kbd.scroll <= kbd.scroll + 4'd1;
              SC_MINUS: if (kbd.scroll != '0) kbd.scroll <= kbd.scroll - 4'd1;
              default:  if (digit[4]) kbd.file_id <= {12'd0, digit[3:0]};
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Directed bench for ps2_keyboard_ctrl: strobes scoreboarded by a monitor, levels checked after each frame.
module tb_ps2_keyboard_ctrl;

  localparam int HALF = 10;

  logic clk_vga;
  logic reset_btn;
  int   vectors;
  int   miscompares;
  logic [6:0] sbq[$];

  ps2_kbd_if kbd ();

  ps2_keyboard_ctrl #(
    .CLK_HZ     (1000000),
    .TIMEOUT_US (200),
    .SHIFT_STEP (16),
    .SCROLL_MAX (4)
  ) dut (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .kbd       (kbd)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // Every non-zero strobe pattern must match the next queued expectation.
  always @(negedge clk_vga) begin
    logic [6:0] pat;
    logic [6:0] exp;
    if (!reset_btn) begin
      pat = {kbd.start, kbd.pause, kbd.clear, kbd.setting};
      if (pat != '0) begin
        exp = (sbq.size() != 0) ? sbq.pop_front() : 7'h7F;
        vectors++;
        assert (pat === exp) else begin
          miscompares++;
          $error("FAIL strobe obs=%b exp=%b", pat, exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int nbits, input bit bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd.ps2_data = fr[i];
      repeat (HALF) @(posedge clk_vga);
      kbd.ps2_clock = 1'b0;
      repeat (HALF) @(posedge clk_vga);
      kbd.ps2_clock = 1'b1;
    end
    kbd.ps2_data = 1'b1;
    repeat (HALF) @(posedge clk_vga);
    @(negedge clk_vga);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 11, 1'b0);
  endtask

  task automatic ext_key(input logic [7:0] b);
    key(8'hE0);
    key(b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {9'd0, kbd.start, kbd.pause, kbd.clear, kbd.setting}, 16'd0);
    chk({tag, "_manual"},  {15'd0, kbd.manual}, 16'd0);
    chk({tag, "_file_id"}, kbd.file_id, 16'd0);
    chk({tag, "_shift_x"}, kbd.shift_x, 16'd0);
    chk({tag, "_shift_y"}, kbd.shift_y, 16'd0);
    chk({tag, "_scroll"},  {12'd0, kbd.scroll}, 16'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    kbd.ps2_clock = 1'b1;
    kbd.ps2_data  = 1'b1;
    reset_btn     = 1'b1;
    repeat (5) @(posedge clk_vga);
    @(negedge clk_vga);
    chk_all_zero("reset");
    reset_btn = 1'b0;
    repeat (5) @(posedge clk_vga);
    @(negedge clk_vga);

    sbq.push_back(7'b100_0000);
    key(8'h5A);
    chk("enter_pulse", 16'(sbq.size()), 16'd0);
    key(8'hF0);
    key(8'h5A);

    key(8'h3A);
    chk("manual_on", {15'd0, kbd.manual}, 16'd1);
    sbq.push_back(7'b000_1000);
    key(8'h23);
    sbq.push_back(7'b000_1000);
    key(8'h23);
    key(8'h3A);
    chk("manual_off", {15'd0, kbd.manual}, 16'd0);
    key(8'h23);
    chk("d_pulses", 16'(sbq.size()), 16'd0);

    for (int i = 0; i < 3; i++) ext_key(8'h74);
    ext_key(8'h6B);
    chk("shift_x_32", kbd.shift_x, 16'd32);
    ext_key(8'h75);
    chk("shift_y_sat0", kbd.shift_y, 16'd0);
    ext_key(8'h72);
    chk("shift_y_16", kbd.shift_y, 16'd16);
    key(8'hF0);
    ext_key(8'h72);
    chk("shift_y_brk", kbd.shift_y, 16'd16);

    key(8'h3D);
    chk("file_id_7", kbd.file_id, 16'd7);
    send(8'h1E, 11, 1'b1);
    chk("file_id_badpar", kbd.file_id, 16'd7);
    key(8'h45);
    chk("file_id_0", kbd.file_id, 16'd0);
    key(8'h3D);

    for (int i = 0; i < 6; i++) key(8'h55);
    chk("scroll_sat4", {12'd0, kbd.scroll}, 16'd4);
    key(8'h4E);
    chk("scroll_3", {12'd0, kbd.scroll}, 16'd3);
    for (int i = 0; i < 4; i++) key(8'h4E);
    chk("scroll_sat0", {12'd0, kbd.scroll}, 16'd0);
    key(8'h55);
    chk("scroll_1", {12'd0, kbd.scroll}, 16'd1);

    sbq.push_back(7'b001_0000);
    key(8'h21);
    chk("clear_pulse", 16'(sbq.size()), 16'd0);

    send(8'h29, 5, 1'b0);
    repeat (300) @(posedge clk_vga);
    @(negedge clk_vga);
    sbq.push_back(7'b010_0000);
    key(8'h29);
    chk("timeout_pause", 16'(sbq.size()), 16'd0);

    key(8'h3A);
    chk("manual_pre_rst", {15'd0, kbd.manual}, 16'd1);
    send(8'h3D, 5, 1'b0);
    @(negedge clk_vga);
    reset_btn = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    reset_btn = 1'b0;
    repeat (5) @(posedge clk_vga);
    @(negedge clk_vga);
    key(8'h3D);
    chk("file_id_after_rst", kbd.file_id, 16'd7);
    chk("final_sb_empty", 16'(sbq.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_ctrl.md
Name: ps2_keyboard_ctrl

Overview:
- PS/2 keyboard front end for the Game-of-Life top level. Receives scan-code set 2 frames from the keyboard and decodes make, break and extended codes.
- Turns key presses into control outputs: run/pause/clear strobes, manual-edit mode and cursor steps, preset file selection, and view pan/zoom registers.
- Consumed by the top-level state machine, the VGA renderer and the SD-card preset loader.

Parameters:
- CLK_HZ, 50000000: clk_vga frequency, used for the frame timeout.
- TIMEOUT_US, 200: idle time that aborts a partial frame.
- SHIFT_STEP, 16: pan increment per arrow-key press.
- SCROLL_MAX, 4: maximum zoom level.

Ports:
- clk_vga in 1: system clock, 50 MHz.
- reset_btn in 1: asynchronous, active-high reset.
- ps2_clock in 1: raw PS/2 clock, asynchronous to clk_vga.
- ps2_data in 1: raw PS/2 data, asynchronous to clk_vga.
- start out 1: one-cycle strobe on Enter make.
- pause out 1: one-cycle strobe on Space make.
- clear out 1: one-cycle strobe on C make.
- manual out 1: level; manual-edit mode flag.
- setting out 4: one-hot cursor step strobe; A=0001, W=0010, S=0100, D=1000, otherwise 0000.
- file_id out 16: selected preset number, 0..9.
- shift_x out 16: horizontal view pan.
- shift_y out 16: vertical view pan.
- scroll out 4: zoom level, 0..SCROLL_MAX.

Behaviour:
- Reset (asynchronous): all outputs 0; receiver idle; break and extended flags cleared.
- Input synchronisation: ps2_clock and ps2_data each pass through 3-flop synchronisers.
- A falling edge of ps2_clock is detected as synchronised sample[2:1]==2'b10. On each falling edge, the synchronised ps2_data is sampled.
- Frame format, 11 bits: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- A frame is accepted only if start==0, stop==1 and parity is odd. Failing frames are silently dropped and the receiver returns to idle.
- Timeout: no falling edge for TIMEOUT_US while mid-frame resets the bit counter to idle.
- Byte-valid latency: rx byte valid is raised 1 cycle after the stop-bit edge. Action outputs update on the following cycle (2 cycles after the stop-bit edge).
- Decode state:
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte is a key code. It is processed with the current ext/brk flags, then both flags are cleared.
  - Break codes (brk=1) produce no action.
  - Typematic repeats (repeated make codes) act each time they arrive.
- Make-code actions, non-extended:
  - 0x5A start pulse; 0x29 pause pulse; 0x21 clear pulse.
  - 0x3A toggles manual.
  - 0x1C A, 0x1D W, 0x1B S, 0x23 D: setting pulse with the matching one-hot value, emitted only while manual==1.
  - Digits 0x45,16,1E,26,25,2E,36,3D,3E,46 load file_id with 0..9.
  - 0x55 (=) increments scroll, saturating at SCROLL_MAX.
  - 0x4E (-) decrements scroll, saturating at 0.
- Make-code actions, extended:
  - 0x6B left: shift_x -= SHIFT_STEP.
  - 0x74 right: shift_x += SHIFT_STEP.
  - 0x75 up: shift_y -= SHIFT_STEP.
  - 0x72 down: shift_y += SHIFT_STEP.
  - All four saturate at 0 and 16'hFFF0.
- Pulse and width rules:
  - start, pause, clear and setting are high for exactly one clk_vga cycle and 0 otherwise. Only one action is possible per byte.
  - Unknown codes are ignored.
  - All arithmetic is unsigned 16-bit with explicit saturation checks; no wrap.
- Reset mid-frame discards the partial byte.

Decomposition:
- Package ps2_kbd_pkg: scan-code localparams (SC_ENTER, SC_SPACE, SC_C, SC_M, SC_A/W/S/D, SC_DIGIT[0:9], SC_EQ, SC_MINUS, SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LEFT/RIGHT/UP/DOWN) and the one-hot setting constants.
- Sub-module ps2_rx: synchronisers, edge detect, shift register, parity check and timeout. Outputs rx_data[7:0] and a one-cycle rx_valid. The top of the block holds only the decoder and the output registers.

Test Plan:
- Send Enter make 0x5A -> start high for exactly 1 cycle. Then send F0 5A -> no further start pulse.
- Send M, then D, then D -> manual=1; setting=4'b1000 pulses twice. Send D with manual=0 -> setting stays 0000.
- Send E0 74 three times, then E0 6B once -> shift_x=32. Send E0 75 from 0 -> shift_y stays 0 (saturates).
- Send digit 7 (0x3D) -> file_id=7. Send a frame 0x3D with bad parity -> file_id unchanged.
- Send '=' six times -> scroll=4 (saturates). Send '-' once -> scroll=3.
- Send 5 bits of a frame, idle 300 us, then a full 0x29 frame -> a single pause pulse. Assert reset_btn mid-frame -> all outputs 0 immediately.
